// File: rtl/hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard/control unit.
// The master drives register IDs and stage status; the slave returns stall/flush/forward controls.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       RsD, RtD, RsE, RtE;
  logic [4:0]       WriteRegE, WriteRegM, WriteRegW;
  logic             RegWriteE, RegWriteM, RegWriteW;
  logic             MemToRegE, JumpD, BranchTakenE;
  logic             MemReqM, MemReadyM;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic [1:0]       ForwardAE, ForwardBE;
  logic [CNT_W-1:0] StallCnt, FlushCnt;
  logic             MemErr;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemToRegE, JumpD, BranchTakenE,
           MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, StallCnt, FlushCnt, MemErr
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemToRegE, JumpD, BranchTakenE,
           MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, StallCnt, FlushCnt, MemErr
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use, branch/jump redirect, data-memory wait with timeout,
// EX-stage operand forwarding, saturating stall/flush counters and a sticky timeout flag.
module hazard_ctrl_unit #(
  parameter int TMO_CYCLES = 64,
  parameter int CNT_W      = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  hazard_ctrl_if.slave  hz
);
  localparam int TMO_W = $clog2(TMO_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             mem_err_q, mem_err_d;

  logic mem_stall, load_use;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w;

  logic [1:0][4:0] src_e;
  logic [1:0][1:0] fwd_sel;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= RUN;
      tmo_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  // tmo counts wait cycles; hitting TMO_LAST aborts the wait instead of stalling again.
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    mem_err_d = mem_err_q;
    mem_stall = 1'b0;
    case (state_q)
      RUN: begin
        tmo_d = '0;
        if (hz.MemReqM && !hz.MemReadyM) begin
          mem_stall = 1'b1;
          state_d   = MEM_WAIT;
          tmo_d     = TMO_W'(1);
        end
      end
      MEM_WAIT: begin
        if (hz.MemReadyM) begin
          state_d = RUN;
          tmo_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          mem_err_d = 1'b1;
          state_d   = RUN;
          tmo_d     = '0;
        end else begin
          mem_stall = 1'b1;
          tmo_d     = tmo_q + 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        tmo_d   = '0;
      end
    endcase
  end

  always_comb begin
    load_use = hz.RegWriteE && hz.MemToRegE && (hz.WriteRegE != 5'd0) &&
               ((hz.WriteRegE == hz.RsD) || (hz.WriteRegE == hz.RtD));
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    // Memory wait freezes everything; EX holds so branch/load-use re-evaluate on release.
    if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (hz.BranchTakenE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else if (hz.JumpD) begin
      flush_d = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = (stall_f && (stall_cnt_q != {CNT_W{1'b1}})) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = (flush_e && (flush_cnt_q != {CNT_W{1'b1}})) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end

  assign src_e[0] = hz.RsE;
  assign src_e[1] = hz.RtE;

  // MEM result is younger than WB, so it wins when both write the same register.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign fwd_sel[gi] =
      (hz.RegWriteM && (hz.WriteRegM != 5'd0) && (hz.WriteRegM == src_e[gi])) ? 2'b10 :
      (hz.RegWriteW && (hz.WriteRegW != 5'd0) && (hz.WriteRegW == src_e[gi])) ? 2'b01 :
      2'b00;
  end

  assign hz.ForwardAE = fwd_sel[0];
  assign hz.ForwardBE = fwd_sel[1];
  assign hz.StallF    = stall_f;
  assign hz.StallD    = stall_d;
  assign hz.StallE    = stall_e;
  assign hz.StallM    = stall_m;
  assign hz.FlushD    = flush_d;
  assign hz.FlushE    = flush_e;
  assign hz.FlushW    = flush_w;
  assign hz.StallCnt  = stall_cnt_q;
  assign hz.FlushCnt  = flush_cnt_q;
  assign hz.MemErr    = mem_err_q;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit (TMO_CYCLES=4, CNT_W=4): expected controls and
// counter values are queued as each cycle is driven and popped when the DUT is sampled.
module tb_hazard_ctrl_unit;
  logic clk;
  logic rst_n;

  hazard_ctrl_if #(.CNT_W(4)) hz ();

  hazard_ctrl_unit #(.TMO_CYCLES(4), .CNT_W(4)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .hz    (hz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;
    logic rwe, rwm, rww, mtr, jmp, br, req, rdy;
  } stim_t;

  typedef struct packed {
    logic [10:0] ctl;
    logic [3:0]  sc;
    logic [3:0]  fc;
    logic        err;
  } exp_t;

  // ctl = {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,ForwardAE,ForwardBE}
  localparam logic [10:0] IDLE = 11'b0000_000_00_00;
  localparam logic [10:0] LU   = 11'b1100_010_00_00;
  localparam logic [10:0] BR   = 11'b0000_110_00_00;
  localparam logic [10:0] JMP  = 11'b0000_100_00_00;
  localparam logic [10:0] MEM  = 11'b1111_001_00_00;

  exp_t        sb[$];
  stim_t       st_q[$];
  logic [10:0] ctl_q[$];
  logic        tmo_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  m_stall = 4'd0;
  logic [3:0]  m_flush = 4'd0;
  logic        m_err   = 1'b0;

  function automatic stim_t mk(input int rsd, rtd, rse, rte, wre, wrm, wrw,
                               input int rwe, rwm, rww, mtr, jmp, br, req, rdy);
    stim_t s;
    s.rsd = 5'(rsd); s.rtd = 5'(rtd); s.rse = 5'(rse); s.rte = 5'(rte);
    s.wre = 5'(wre); s.wrm = 5'(wrm); s.wrw = 5'(wrw);
    s.rwe = 1'(rwe); s.rwm = 1'(rwm); s.rww = 1'(rww); s.mtr = 1'(mtr);
    s.jmp = 1'(jmp); s.br = 1'(br); s.req = 1'(req); s.rdy = 1'(rdy);
    return s;
  endfunction

  // Reference counters: advance on the expected StallF/FlushE, saturate at 15.
  function automatic exp_t mk_exp(input logic [10:0] ctl, input logic tmo_hit);
    exp_t e;
    if (ctl[10] && m_stall != 4'hF) m_stall = m_stall + 4'd1;
    if (ctl[5] && m_flush != 4'hF) m_flush = m_flush + 4'd1;
    m_err = m_err | tmo_hit;
    e.ctl = ctl; e.sc = m_stall; e.fc = m_flush; e.err = m_err;
    return e;
  endfunction

  function automatic logic [10:0] ctl_now();
    return {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushW,
            hz.ForwardAE, hz.ForwardBE};
  endfunction

  task automatic drive(input stim_t s);
    hz.RsD = s.rsd; hz.RtD = s.rtd; hz.RsE = s.rse; hz.RtE = s.rte;
    hz.WriteRegE = s.wre; hz.WriteRegM = s.wrm; hz.WriteRegW = s.wrw;
    hz.RegWriteE = s.rwe; hz.RegWriteM = s.rwm; hz.RegWriteW = s.rww;
    hz.MemToRegE = s.mtr; hz.JumpD = s.jmp; hz.BranchTakenE = s.br;
    hz.MemReqM = s.req; hz.MemReadyM = s.rdy;
  endtask

  task automatic add(input stim_t s, input logic [10:0] c, input logic t);
    st_q.push_back(s); ctl_q.push_back(c); tmo_q.push_back(t);
  endtask

  task automatic test_reset();
    drive('0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({hz.StallCnt, hz.FlushCnt, hz.MemErr} !== 9'b0) begin
      errors++;
      $display("FAIL reset_regs got %0d/%0d/%b want 0/0/0", hz.StallCnt, hz.FlushCnt, hz.MemErr);
    end
    checks++;
    if (ctl_now() !== IDLE) begin
      errors++;
      $display("FAIL reset_ctl got %b want %b", ctl_now(), IDLE);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    exp_t e;
    add(mk(8,0,0,0, 8,0,0, 1,0,0, 1,0,0,0,0), LU, 1'b0);
    add(mk(0,8,0,0, 8,0,0, 1,0,0, 1,0,0,0,0), LU, 1'b0);
    add(mk(0,0,0,0, 0,0,0, 1,0,0, 1,0,0,0,0), IDLE, 1'b0);
    add(mk(8,0,0,0, 8,0,0, 1,0,0, 0,0,0,0,0), IDLE, 1'b0);
    add(mk(8,0,0,0, 8,0,0, 0,0,0, 1,0,0,0,0), IDLE, 1'b0);
    add(mk(3,4,0,0, 8,0,0, 1,0,0, 1,0,0,0,0), IDLE, 1'b0);
    for (int i = 0; st_q.size() > 0; i++) begin
      drive(st_q.pop_front());
      sb.push_back(mk_exp(ctl_q.pop_front(), tmo_q.pop_front()));
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctl_now() !== e.ctl) begin
        errors++;
        $display("FAIL load_use[%0d] ctl got %b want %b", i, ctl_now(), e.ctl);
      end
      @(posedge clk); #1;
      checks++;
      if ({hz.StallCnt, hz.FlushCnt, hz.MemErr} !== {e.sc, e.fc, e.err}) begin
        errors++;
        $display("FAIL load_use[%0d] cnt got %0d/%0d/%b want %0d/%0d/%b", i,
                 hz.StallCnt, hz.FlushCnt, hz.MemErr, e.sc, e.fc, e.err);
      end
    end
  endtask

  task automatic test_branch_jump();
    exp_t e;
    add(mk(8,0,0,0, 8,0,0, 1,0,0, 1,0,1,0,0), BR, 1'b0);
    add(mk(0,0,0,0, 0,0,0, 0,0,0, 0,1,0,0,0), JMP, 1'b0);
    add(mk(8,0,0,0, 8,0,0, 1,0,0, 1,1,0,0,0), LU, 1'b0);
    add(mk(0,0,0,0, 0,0,0, 0,0,0, 0,0,1,0,0), BR, 1'b0);
    add(mk(0,0,0,0, 0,0,0, 0,0,0, 0,1,1,0,0), BR, 1'b0);
    for (int i = 0; st_q.size() > 0; i++) begin
      drive(st_q.pop_front());
      sb.push_back(mk_exp(ctl_q.pop_front(), tmo_q.pop_front()));
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctl_now() !== e.ctl) begin
        errors++;
        $display("FAIL branch_jump[%0d] ctl got %b want %b", i, ctl_now(), e.ctl);
      end
      @(posedge clk); #1;
      checks++;
      if ({hz.StallCnt, hz.FlushCnt, hz.MemErr} !== {e.sc, e.fc, e.err}) begin
        errors++;
        $display("FAIL branch_jump[%0d] cnt got %0d/%0d/%b want %0d/%0d/%b", i,
                 hz.StallCnt, hz.FlushCnt, hz.MemErr, e.sc, e.fc, e.err);
      end
    end
  endtask

  task automatic test_forward();
    exp_t e;
    add(mk(0,0,5,0, 0,5,5, 0,1,1, 0,0,0,0,0), 11'b0000_000_10_00, 1'b0);
    add(mk(0,0,5,5, 0,5,5, 0,1,1, 0,0,0,0,0), 11'b0000_000_10_10, 1'b0);
    add(mk(0,0,5,5, 0,5,5, 0,0,1, 0,0,0,0,0), 11'b0000_000_01_01, 1'b0);
    add(mk(0,0,0,0, 0,0,0, 0,1,1, 0,0,0,0,0), 11'b0000_000_00_00, 1'b0);
    add(mk(0,0,5,7, 0,7,5, 0,1,1, 0,0,0,0,0), 11'b0000_000_01_10, 1'b0);
    add(mk(0,0,9,3, 0,9,9, 0,1,0, 0,0,0,0,0), 11'b0000_000_10_00, 1'b0);
    for (int i = 0; st_q.size() > 0; i++) begin
      drive(st_q.pop_front());
      sb.push_back(mk_exp(ctl_q.pop_front(), tmo_q.pop_front()));
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctl_now() !== e.ctl) begin
        errors++;
        $display("FAIL forward[%0d] ctl got %b want %b", i, ctl_now(), e.ctl);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_wait();
    exp_t e;
    for (int k = 0; k < 3; k++) add(mk(0,0,0,0, 0,0,0, 0,0,0, 0,0,1,1,0), MEM, 1'b0);
    add(mk(0,0,0,0, 0,0,0, 0,0,0, 0,0,1,1,1), BR, 1'b0);
    add(mk(0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0), IDLE, 1'b0);
    for (int i = 0; st_q.size() > 0; i++) begin
      drive(st_q.pop_front());
      sb.push_back(mk_exp(ctl_q.pop_front(), tmo_q.pop_front()));
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctl_now() !== e.ctl) begin
        errors++;
        $display("FAIL mem_wait[%0d] ctl got %b want %b", i, ctl_now(), e.ctl);
      end
      @(posedge clk); #1;
      checks++;
      if ({hz.StallCnt, hz.FlushCnt, hz.MemErr} !== {e.sc, e.fc, e.err}) begin
        errors++;
        $display("FAIL mem_wait[%0d] cnt got %0d/%0d/%b want %0d/%0d/%b", i,
                 hz.StallCnt, hz.FlushCnt, hz.MemErr, e.sc, e.fc, e.err);
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    for (int k = 0; k < 4; k++) add(mk(0,0,0,0, 0,0,0, 0,0,0, 0,0,0,1,0), MEM, 1'b0);
    add(mk(0,0,0,0, 0,0,0, 0,0,0, 0,0,0,1,0), IDLE, 1'b1);
    for (int k = 0; k < 2; k++) add(mk(0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0), IDLE, 1'b0);
    for (int i = 0; st_q.size() > 0; i++) begin
      drive(st_q.pop_front());
      sb.push_back(mk_exp(ctl_q.pop_front(), tmo_q.pop_front()));
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctl_now() !== e.ctl) begin
        errors++;
        $display("FAIL timeout[%0d] ctl got %b want %b", i, ctl_now(), e.ctl);
      end
      @(posedge clk); #1;
      checks++;
      if ({hz.StallCnt, hz.FlushCnt, hz.MemErr} !== {e.sc, e.fc, e.err}) begin
        errors++;
        $display("FAIL timeout[%0d] cnt got %0d/%0d/%b want %0d/%0d/%b", i,
                 hz.StallCnt, hz.FlushCnt, hz.MemErr, e.sc, e.fc, e.err);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive(mk(0,0,0,0, 0,0,0, 0,0,0, 0,0,0,1,0));
      sb.push_back(mk_exp(MEM, 1'b0));
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctl_now() !== e.ctl) begin
        errors++;
        $display("FAIL rst_wait[%0d] ctl got %b want %b", i, ctl_now(), e.ctl);
      end
      @(posedge clk); #1;
    end
    // Idle inputs: a leftover MEM_WAIT state would still stall here.
    drive('0);
    rst_n = 1'b0;
    m_stall = 4'd0; m_flush = 4'd0; m_err = 1'b0;
    #1;
    checks++;
    if ({hz.StallCnt, hz.FlushCnt, hz.MemErr} !== 9'b0) begin
      errors++;
      $display("FAIL rst_wait async got %0d/%0d/%b want 0/0/0", hz.StallCnt, hz.FlushCnt, hz.MemErr);
    end
    @(negedge clk);
    checks++;
    if (ctl_now() !== IDLE) begin
      errors++;
      $display("FAIL rst_wait state got %b want %b", ctl_now(), IDLE);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.push_back(mk_exp(IDLE, 1'b0));
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (ctl_now() !== e.ctl) begin
      errors++;
      $display("FAIL rst_wait post ctl got %b want %b", ctl_now(), e.ctl);
    end
    @(posedge clk); #1;
    checks++;
    if ({hz.StallCnt, hz.FlushCnt, hz.MemErr} !== {e.sc, e.fc, e.err}) begin
      errors++;
      $display("FAIL rst_wait post cnt got %0d/%0d/%b want %0d/%0d/%b",
               hz.StallCnt, hz.FlushCnt, hz.MemErr, e.sc, e.fc, e.err);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    for (int k = 0; k < 20; k++) add(mk(8,0,0,0, 8,0,0, 1,0,0, 1,0,0,0,0), LU, 1'b0);
    add(mk(0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0), IDLE, 1'b0);
    for (int i = 0; st_q.size() > 0; i++) begin
      drive(st_q.pop_front());
      sb.push_back(mk_exp(ctl_q.pop_front(), tmo_q.pop_front()));
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (ctl_now() !== e.ctl) begin
        errors++;
        $display("FAIL saturate[%0d] ctl got %b want %b", i, ctl_now(), e.ctl);
      end
      @(posedge clk); #1;
      checks++;
      if ({hz.StallCnt, hz.FlushCnt, hz.MemErr} !== {e.sc, e.fc, e.err}) begin
        errors++;
        $display("FAIL saturate[%0d] cnt got %0d/%0d/%b want %0d/%0d/%b", i,
                 hz.StallCnt, hz.FlushCnt, hz.MemErr, e.sc, e.fc, e.err);
      end
    end
    checks++;
    if (hz.StallCnt !== 4'd15 || hz.FlushCnt !== 4'd15) begin
      errors++;
      $display("FAIL saturate final got %0d/%0d want 15/15", hz.StallCnt, hz.FlushCnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_jump();
    test_forward();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
